// File: rtl/regfile_write_scheduler.sv
// Register file write-port scheduler.
// After reset it clears registers 1..2**ADDR_W-1 to zero, then round-robin arbitrates
// two writeback requesters onto the single registered write port (A3/WD3/WE3).
module regfile_write_scheduler #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 5,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic              WE3,
    output logic              init_done
);

    typedef enum logic [1:0] {
        StRstHold = 2'b00,
        StClear   = 2'b01,
        StRun     = 2'b10
    } state_e;

    localparam logic [ADDR_W-1:0] LastAddr = '1;

    state_e            state;
    logic [ADDR_W-1:0] clear_cnt;
    // Index of the requester granted most recently; reset to 1 so req0 wins the first tie.
    logic              last_grant;
    logic              grant0;
    logic              grant1;

    // Round-robin grant, only while running; a contested grant goes to the other requester.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == StRun) begin
            grant0 = req0_valid && (!req1_valid || last_grant);
            grant1 = req1_valid && (!req0_valid || !last_grant);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Sequencer FSM with registered write-port outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= StRstHold;
            A3         <= '0;
            WD3        <= '0;
            WE3        <= 1'b0;
            init_done  <= 1'b0;
            clear_cnt  <= ADDR_W'(1);
            last_grant <= 1'b1;
        end else begin
            case (state)
                StRstHold: begin
                    WE3 <= 1'b0;
                    if (CLEAR_ON_RESET) begin
                        state <= StClear;
                    end else begin
                        state     <= StRun;
                        init_done <= 1'b1;
                    end
                end
                StClear: begin
                    A3        <= clear_cnt;
                    WD3       <= '0;
                    WE3       <= 1'b1;
                    clear_cnt <= clear_cnt + ADDR_W'(1);
                    // init_done rises together with the write of the last register.
                    if (clear_cnt == LastAddr) begin
                        state     <= StRun;
                        init_done <= 1'b1;
                    end
                end
                StRun: begin
                    if (grant0) begin
                        A3         <= req0_addr;
                        WD3        <= req0_data;
                        WE3        <= (req0_addr != '0);
                        last_grant <= 1'b0;
                    end else if (grant1) begin
                        A3         <= req1_addr;
                        WD3        <= req1_data;
                        WE3        <= (req1_addr != '0);
                        last_grant <= 1'b1;
                    end else begin
                        // A3/WD3 hold their previous values when idle.
                        WE3 <= 1'b0;
                    end
                end
                default: begin
                    state <= StRstHold;
                    WE3   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: clear sequence, reset behaviour,
// arbitration scenarios and a randomized run against a transaction-level model.
module tb_regfile_write_scheduler;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, v1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;

    logic          r0, r1, we3, idone;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;
    logic          n_r0, n_r1, n_we3, n_idone;
    logic [AW-1:0] n_a3;
    logic [DW-1:0] n_wd3;

    int checks = 0;
    int errors = 0;
    int m_last;

    always #5 clk = ~clk;

    regfile_write_scheduler #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .CLK(clk), .RESET(rst),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1),
        .A3(a3), .WD3(wd3), .WE3(we3), .init_done(idone)
    );

    regfile_write_scheduler #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b0)) dut_nc (
        .CLK(clk), .RESET(rst),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(n_r0),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(n_r1),
        .A3(n_a3), .WD3(n_wd3), .WE3(n_we3), .init_done(n_idone)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        v0  = 1'b0;
        v1  = 1'b0;
        repeat (n) step();
        rst    = 1'b0;
        m_last = 1;
    endtask

    task automatic wait_init();
        int w = 0;
        while (idone !== 1'b1 && w < 60) begin
            step();
            w++;
        end
        checks++;
        if (idone !== 1'b1) begin
            errors++;
            $display("FAIL wait_init: init_done=%b after %0d cycles, expected 1", idone, w);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v0 = 1'b1; a0 = 5'd3; d0 = 32'h11;
        v1 = 1'b1; a1 = 5'd7; d1 = 32'h22;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (we3 !== 1'b0 || idone !== 1'b0 || a3 !== '0 || wd3 !== '0) begin
                errors++;
                $display("FAIL reset_regs: we3=%b init=%b a3=%0d wd3=%h, expected 0/0/0/0",
                         we3, idone, a3, wd3);
            end
            checks++;
            if (r0 !== 1'b0 || r1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready: r0=%b r1=%b, expected 0 0", r0, r1);
            end
        end
    endtask

    task automatic test_clear();
        int w = 0;
        rst = 1'b0;
        step();
        while (we3 !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        checks++;
        if (we3 !== 1'b1) begin
            errors++;
            $display("FAIL clear_start: we3=%b, expected 1 within 40 cycles", we3);
        end
        for (int k = 1; k <= 31; k++) begin
            checks++;
            if (we3 !== 1'b1 || a3 !== AW'(k) || wd3 !== '0) begin
                errors++;
                $display("FAIL clear_write k=%0d: we3=%b a3=%0d wd3=%h, expected 1 %0d 0",
                         k, we3, a3, wd3, k);
            end
            checks++;
            if (idone !== (k == 31)) begin
                errors++;
                $display("FAIL clear_init k=%0d: init_done=%b, expected %0d", k, idone, k == 31);
            end
            if (k < 31) begin
                checks++;
                if (r0 !== 1'b0 || r1 !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_ready k=%0d: r0=%b r1=%b, expected 0 0", k, r0, r1);
                end
                step();
            end else begin
                v0 = 1'b0;
                v1 = 1'b0;
            end
        end
        step();
        checks++;
        if (we3 !== 1'b0 || idone !== 1'b1) begin
            errors++;
            $display("FAIL clear_end: we3=%b init=%b, expected 0 1", we3, idone);
        end
    endtask

    task automatic test_mid_clear_reset();
        int w = 0;
        int exp_a;
        apply_reset(2);
        while (!(we3 === 1'b1 && a3 === 5'd10) && w < 60) begin
            step();
            w++;
        end
        checks++;
        if (a3 !== 5'd10 || we3 !== 1'b1) begin
            errors++;
            $display("FAIL midclr_reach: a3=%0d we3=%b, expected 10 1", a3, we3);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (we3 !== 1'b0 || idone !== 1'b0) begin
                errors++;
                $display("FAIL midclr_hold cyc=%0d: we3=%b init=%b, expected 0 0", i, we3, idone);
            end
        end
        rst = 1'b0;
        w = 0;
        step();
        while (we3 !== 1'b1 && w < 10) begin
            step();
            w++;
        end
        exp_a = 1;
        while (exp_a <= 31) begin
            checks++;
            if (we3 !== 1'b1 || a3 !== AW'(exp_a)) begin
                errors++;
                $display("FAIL midclr_restart: we3=%b a3=%0d, expected 1 %0d", we3, a3, exp_a);
                exp_a = 32;
            end else begin
                if (exp_a < 31) step();
                exp_a++;
            end
        end
        checks++;
        if (idone !== 1'b1) begin
            errors++;
            $display("FAIL midclr_done: init_done=%b, expected 1", idone);
        end
        step();
    endtask

    task automatic test_single_req0();
        apply_reset(2);
        wait_init();
        step();
        v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
        #1;
        checks++;
        if (r0 !== 1'b1 || r1 !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: r0=%b r1=%b, expected 1 0", r0, r1);
        end
        step();
        v0 = 1'b0;
        checks++;
        if (we3 !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_write: we3=%b a3=%0d wd3=%h, expected 1 5 deadbeef",
                     we3, a3, wd3);
        end
        step();
        checks++;
        if (we3 !== 1'b0 || a3 !== 5'd5 || wd3 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_idle: we3=%b a3=%0d wd3=%h, expected 0 5 deadbeef (held)",
                     we3, a3, wd3);
        end
    endtask

    task automatic test_back_to_back();
        int exp_prev_a = 0;
        apply_reset(2);
        wait_init();
        step();
        v0 = 1'b1; a0 = 5'd3; d0 = 32'h11;
        v1 = 1'b1; a1 = 5'd7; d1 = 32'h22;
        #1;
        for (int i = 0; i < 4; i++) begin
            int g = i % 2;
            if (i > 0) begin
                checks++;
                if (we3 !== 1'b1 || a3 !== AW'(exp_prev_a)) begin
                    errors++;
                    $display("FAIL b2b_write i=%0d: we3=%b a3=%0d, expected 1 %0d",
                             i, we3, a3, exp_prev_a);
                end
            end
            checks++;
            if (r0 !== (g == 0) || r1 !== (g == 1)) begin
                errors++;
                $display("FAIL b2b_grant i=%0d: r0=%b r1=%b, expected %0d %0d",
                         i, r0, r1, g == 0, g == 1);
            end
            exp_prev_a = (g == 0) ? 3 : 7;
            step();
        end
        v0 = 1'b0;
        v1 = 1'b0;
        checks++;
        if (we3 !== 1'b1 || a3 !== 5'd7 || wd3 !== 32'h22) begin
            errors++;
            $display("FAIL b2b_last: we3=%b a3=%0d wd3=%h, expected 1 7 22", we3, a3, wd3);
        end
        m_last = 1;
    endtask

    task automatic test_addr0();
        step();
        v1 = 1'b1; a1 = 5'd0; d1 = 32'hFFFFFFFF;
        #1;
        checks++;
        if (r1 !== 1'b1) begin
            errors++;
            $display("FAIL addr0_ready: r1=%b, expected 1", r1);
        end
        step();
        v1 = 1'b0;
        checks++;
        if (we3 !== 1'b0) begin
            errors++;
            $display("FAIL addr0_we: we3=%b, expected 0", we3);
        end
    endtask

    task automatic test_random();
        int winner;
        logic          exp_we;
        logic [AW-1:0] exp_a, held_a;
        logic [DW-1:0] exp_d, held_d;
        bit            held_known = 1'b0;
        apply_reset(2);
        wait_init();
        step();
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!v0 && $urandom_range(2) != 0) begin
                v0 = 1'b1; a0 = AW'($urandom_range(31)); d0 = $urandom;
            end
            if (!v1 && $urandom_range(2) != 0) begin
                v1 = 1'b1; a1 = AW'($urandom_range(31)); d1 = $urandom;
            end
            #1;
            // Model: a lone requester wins; a contested cycle alternates away from the last winner.
            if (v0 && v1)  winner = 1 - m_last;
            else if (v0)   winner = 0;
            else if (v1)   winner = 1;
            else           winner = -1;
            checks++;
            if (r0 !== (winner == 0) || r1 !== (winner == 1)) begin
                errors++;
                $display("FAIL rand_grant cyc=%0d v=%b%b: r0=%b r1=%b, expected winner %0d",
                         cyc, v0, v1, r0, r1, winner);
            end
            exp_we = 1'b0;
            exp_a  = '0;
            exp_d  = '0;
            if (winner == 0) begin exp_a = a0; exp_d = d0; end
            if (winner == 1) begin exp_a = a1; exp_d = d1; end
            if (winner >= 0) exp_we = (exp_a != '0);
            step();
            checks++;
            if (we3 !== exp_we) begin
                errors++;
                $display("FAIL rand_we cyc=%0d: we3=%b, expected %b", cyc, we3, exp_we);
            end else if (exp_we && (a3 !== exp_a || wd3 !== exp_d)) begin
                errors++;
                $display("FAIL rand_data cyc=%0d: a3=%0d wd3=%h, expected %0d %h",
                         cyc, a3, wd3, exp_a, exp_d);
            end else if (winner < 0 && held_known && (a3 !== held_a || wd3 !== held_d)) begin
                errors++;
                $display("FAIL rand_hold cyc=%0d: a3=%0d wd3=%h, expected held %0d %h",
                         cyc, a3, wd3, held_a, held_d);
            end
            if (exp_we) begin
                held_a = exp_a; held_d = exp_d; held_known = 1'b1;
            end else if (winner >= 0) begin
                held_known = 1'b0;
            end
            if (winner == 0) v0 = 1'b0;
            if (winner == 1) v1 = 1'b0;
            if (winner >= 0) m_last = winner;
        end
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic test_no_clear();
        apply_reset(2);
        checks++;
        if (n_idone !== 1'b0 || n_we3 !== 1'b0) begin
            errors++;
            $display("FAIL nc_reset: init=%b we3=%b, expected 0 0", n_idone, n_we3);
        end
        step();
        checks++;
        if (n_idone !== 1'b1 || n_we3 !== 1'b0) begin
            errors++;
            $display("FAIL nc_init: init=%b we3=%b, expected 1 0", n_idone, n_we3);
        end
        v0 = 1'b1; a0 = 5'd9; d0 = 32'h12345678;
        #1;
        checks++;
        if (n_r0 !== 1'b1) begin
            errors++;
            $display("FAIL nc_ready: r0=%b, expected 1", n_r0);
        end
        step();
        v0 = 1'b0;
        checks++;
        if (n_we3 !== 1'b1 || n_a3 !== 5'd9 || n_wd3 !== 32'h12345678) begin
            errors++;
            $display("FAIL nc_write: we3=%b a3=%0d wd3=%h, expected 1 9 12345678",
                     n_we3, n_a3, n_wd3);
        end
    endtask

    initial begin
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        m_last = 1;
        test_reset();
        test_clear();
        test_mid_clear_reset();
        test_single_req0();
        test_back_to_back();
        test_addr0();
        test_random();
        test_no_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
